// File: rtl/aes_key_expand_pkg.sv
// Shared AES-128 key schedule definitions: round count, FSM states and
// the small word helpers used by the expansion step.
package aes_key_expand_pkg;

  localparam int AES_NR = 10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  // Index is (round - 1); indices 10..15 are never produced by the counter.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One combinational AES-128 key schedule step: previous round key plus the
// externally substituted RotWord(w3) produce the next round key.
module aes_key_expand_step
  import aes_key_expand_pkg::*;
(
  input  logic [127:0] i_prev_key,
  input  logic [31:0]  i_sbox_out,
  input  logic [7:0]   i_rcon,
  output logic [31:0]  o_sbox_in,
  output logic [127:0] o_next_key
);

  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [31:0] w_w2;
  logic [31:0] w_w3;
  logic [31:0] w_t;
  logic [31:0] w_w4;
  logic [31:0] w_w5;
  logic [31:0] w_w6;
  logic [31:0] w_w7;

  assign {w_w0, w_w1, w_w2, w_w3} = i_prev_key;

  // The S-box lives in the round datapath; we only hand it the rotated word.
  assign o_sbox_in = rot_word(w_w3);
  assign w_t       = i_sbox_out ^ {i_rcon, 24'h000000};

  assign w_w4 = w_w0 ^ w_t;
  assign w_w5 = w_w1 ^ w_w4;
  assign w_w6 = w_w2 ^ w_w5;
  assign w_w7 = w_w3 ^ w_w6;

  assign o_next_key = {w_w4, w_w5, w_w6, w_w7};

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands the cipher key into rk0..rk10, one round key
// per clock, borrowing the round's S-box, and serves keys by index.
module aes_key_expand
  import aes_key_expand_pkg::*;
#(
  parameter int NR      = AES_NR,
  parameter int OUT_REG = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [127:0] i_cipher_key,
  output logic         o_sbox_req,
  output logic [31:0]  o_sbox_in,
  input  logic [31:0]  i_sbox_out,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_key_valid,
  input  logic [3:0]   i_rk_idx,
  output logic [127:0] o_roundkey
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t       r_state;
  state_t       w_state_next;
  logic [3:0]   r_round;
  logic         r_done;
  logic         r_key_valid;
  logic [127:0] r_rk [0:NR];

  logic         w_expanding;
  logic         w_start_ok;
  logic         w_last;
  logic [3:0]   w_prev_idx;
  logic [7:0]   w_rcon;
  logic [127:0] w_prev_key;
  logic [127:0] w_next_key;
  logic [31:0]  w_step_sbox_in;
  logic [127:0] w_rd_key;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_expanding  = 1'b0;
    w_start_ok   = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_start_ok   = 1'b1;
          w_state_next = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        w_expanding = 1'b1;
        if (r_round == LAST_ROUND) begin
          w_last       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Counter parks at 0 between expansions so it never runs past the last round.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_round     <= 4'd0;
      r_done      <= 1'b0;
      r_key_valid <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_start_ok) begin
        r_round     <= 4'd1;
        r_key_valid <= 1'b0;
      end else if (w_last) begin
        r_round     <= 4'd0;
        r_key_valid <= 1'b1;
      end else if (w_expanding) begin
        r_round <= r_round + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_start_ok) begin
      r_rk[0] <= i_cipher_key;
    end else if (w_expanding) begin
      r_rk[r_round] <= w_next_key;
    end
  end

  assign w_prev_idx = r_round - 4'd1;
  assign w_prev_key = (w_prev_idx <= LAST_ROUND) ? r_rk[w_prev_idx] : '0;
  assign w_rcon     = rcon(w_prev_idx);

  aes_key_expand_step u_step (
    .i_prev_key (w_prev_key),
    .i_sbox_out (i_sbox_out),
    .i_rcon     (w_rcon),
    .o_sbox_in  (w_step_sbox_in),
    .o_next_key (w_next_key)
  );

  assign o_sbox_req  = w_expanding;
  assign o_sbox_in   = w_expanding ? w_step_sbox_in : 32'h0;
  assign o_busy      = w_expanding;
  assign o_done      = r_done;
  assign o_key_valid = r_key_valid;

  // No write bypass: a read of the slot being written returns its old contents.
  assign w_rd_key = (i_rk_idx <= LAST_ROUND) ? r_rk[i_rk_idx] : '0;

  if (OUT_REG != 0) begin : g_out_reg
    logic [127:0] r_roundkey;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_roundkey <= '0;
      end else begin
        r_roundkey <= w_rd_key;
      end
    end
    assign o_roundkey = r_roundkey;
  end else begin : g_out_comb
    assign o_roundkey = w_rd_key;
  end

endmodule
